// File: rtl/gcn_transform_sched.sv
// Sequencer for the GCN combination phase: walks FM x WM column-major, fetching
// operands, launching the dot-product unit and writing each result to FM_WM.
module gcn_transform_sched #(
    parameter int                       FEATURE_ROWS   = 6,
    parameter int                       WEIGHT_COLS    = 3,
    parameter int                       ADDRESS_WIDTH  = 13,
    parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE   = 'h200,
    parameter int                       DOT_PROD_WIDTH = 16,
    parameter int                       DP_TIMEOUT     = 255
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    output logic                              enable_read,
    output logic [ADDRESS_WIDTH-1:0]          read_address,
    output logic                              load_weight,
    output logic                              load_feature,
    output logic                              dp_start,
    input  logic                              dp_done,
    input  logic [DOT_PROD_WIDTH-1:0]         dp_result,
    output logic                              wr_en,
    output logic [$clog2(FEATURE_ROWS)-1:0]   wr_row,
    output logic [$clog2(WEIGHT_COLS)-1:0]    wr_col,
    output logic [DOT_PROD_WIDTH-1:0]         wr_data,
    output logic                              busy,
    output logic                              done,
    output logic                              error
);

    localparam int ROW_W = $clog2(FEATURE_ROWS);
    localparam int COL_W = $clog2(WEIGHT_COLS);
    localparam int WD_W  = $clog2(DP_TIMEOUT + 1);

    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FEATURE_ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WEIGHT_COLS - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(DP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_F,
        S_START,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [ROW_W-1:0]          row_q, row_d;
    logic [COL_W-1:0]          col_q, col_d;
    logic [WD_W-1:0]           wd_q, wd_d;
    logic [DOT_PROD_WIDTH-1:0] res_q, res_d;
    logic                      err_q, err_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            wd_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            wd_q    <= wd_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        wd_d         = wd_q;
        res_d        = res_q;
        err_d        = err_q;
        enable_read  = 1'b0;
        read_address = '0;
        load_weight  = 1'b0;
        load_feature = 1'b0;
        dp_start     = 1'b0;
        wr_en        = 1'b0;
        wr_row       = '0;
        wr_col       = '0;
        wr_data      = '0;
        done         = 1'b0;
        busy         = 1'b1;
        error        = err_q;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    row_d   = '0;
                    col_d   = '0;
                    state_d = S_LOAD_W;
                end
            end
            S_LOAD_W: begin
                enable_read  = 1'b1;
                read_address = ADDRESS_WIDTH'(col_q);
                load_weight  = 1'b1;
                state_d      = S_LOAD_F;
            end
            S_LOAD_F: begin
                enable_read  = 1'b1;
                read_address = FEATURE_BASE + ADDRESS_WIDTH'(row_q);
                load_feature = 1'b1;
                state_d      = S_START;
            end
            S_START: begin
                dp_start = 1'b1;
                wd_d     = '0;
                if (dp_done) begin
                    res_d   = dp_result;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // dp_done wins over the watchdog on the final allowed cycle
                if (dp_done) begin
                    res_d   = dp_result;
                    state_d = S_WRITE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_row  = row_q;
                wr_col  = col_q;
                wr_data = res_q;
                if (row_q != ROW_LAST) begin
                    row_d   = row_q + 1'b1;
                    state_d = S_LOAD_F;
                end else if (col_q != COL_LAST) begin
                    row_d   = '0;
                    col_d   = col_q + 1'b1;
                    state_d = S_LOAD_W;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy = 1'b0;
                done = 1'b1;
                if (!start) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcn_transform_sched.sv
// Directed bench for gcn_transform_sched with a configurable-latency dot-product
// model (result = row*16+col), spurious dp_done injection and a hang mode.
module tb_gcn_transform_sched;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start;
    logic        enable_read;
    logic [12:0] read_address;
    logic        load_weight;
    logic        load_feature;
    logic        dp_start;
    logic        dp_done;
    logic [15:0] dp_result;
    logic        wr_en;
    logic [2:0]  wr_row;
    logic [1:0]  wr_col;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    gcn_transform_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .enable_read  (enable_read),
        .read_address (read_address),
        .load_weight  (load_weight),
        .load_feature (load_feature),
        .dp_start     (dp_start),
        .dp_done      (dp_done),
        .dp_result    (dp_result),
        .wr_en        (wr_en),
        .wr_row       (wr_row),
        .wr_col       (wr_col),
        .wr_data      (wr_data),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    // ---------------- dot-product model ----------------
    logic        model_clr = 1'b1;
    int          n_lat = 0;
    logic        inject = 1'b0;
    int          hang_after = 0;
    int          elem_cnt;
    logic        pending;
    int          remain;
    logic [15:0] cur_res;
    logic        suppress;
    logic        model_done;
    logic        spur;

    function automatic logic [15:0] f_res(input int e);
        return 16'(((e % 6) * 16) + ((e / 6) % 3));
    endfunction

    always @(posedge clk) begin
        if (model_clr) begin
            elem_cnt <= 0;
            pending  <= 1'b0;
            remain   <= 0;
            cur_res  <= '0;
        end else if (dp_start) begin
            elem_cnt <= elem_cnt + 1;
            cur_res  <= f_res(elem_cnt);
            if (n_lat != 0) begin
                pending <= 1'b1;
                remain  <= n_lat - 1;
            end
        end else if (pending) begin
            if (remain == 0) pending <= 1'b0;
            else             remain  <= remain - 1;
        end
    end

    assign suppress   = (hang_after != 0) && ((elem_cnt + (dp_start ? 1 : 0)) >= hang_after);
    assign model_done = !suppress && ((n_lat == 0) ? dp_start : (pending && remain == 0));
    assign spur       = inject && (load_feature || wr_en);
    assign dp_done    = model_done || spur;
    assign dp_result  = spur ? 16'hDEAD : (dp_start ? f_res(elem_cnt) : cur_res);

    // ---------------- expected-value generators ----------------
    function automatic logic [20:0] exp_wr(input int i);
        return {3'(i % 6), 2'(i / 6), 16'(((i % 6) * 16) + (i / 6))};
    endfunction

    function automatic logic [12:0] exp_rd(input int i);
        int c;
        int p;
        c = i / 7;
        p = i % 7;
        if (p == 0) return 13'(c);
        return 13'(32'h200 + p - 1);
    endfunction

    // ---------------- run recorder ----------------
    logic [12:0] rd_q[$];
    logic [20:0] wr_q[$];
    int done_edge, first_dps_edge, first_wr_edge, third_dps_edge;
    int dps_cnt, dps_double, busy_gap;

    task automatic prep(input int n, input logic inj, input int hang);
        start      = 1'b0;
        n_lat      = n;
        inject     = inj;
        hang_after = hang;
        model_clr  = 1'b1;
        @(posedge clk); #1;
        model_clr  = 1'b0;
    endtask

    // Raises start; the next rising edge is edge 0 (start sampled in IDLE).
    task automatic collect_run(input int max_edges);
        logic prev_dps;
        rd_q.delete();
        wr_q.delete();
        done_edge = -1; first_dps_edge = -1; first_wr_edge = -1; third_dps_edge = -1;
        dps_cnt = 0; dps_double = 0; busy_gap = 0;
        prev_dps = 1'b0;
        start = 1'b1;
        for (int k = 0; k <= max_edges; k++) begin
            @(posedge clk); #1;
            if (enable_read) rd_q.push_back(read_address);
            if (dp_start) begin
                dps_cnt++;
                if (prev_dps) dps_double++;
                if (first_dps_edge < 0) first_dps_edge = k;
                if (dps_cnt == 3) third_dps_edge = k;
            end
            prev_dps = dp_start;
            if (wr_en) begin
                wr_q.push_back({wr_row, wr_col, wr_data});
                if (first_wr_edge < 0) first_wr_edge = k;
            end
            if (done) begin
                done_edge = k;
                break;
            end
            if (!busy) busy_gap++;
        end
        $display("run: writes=%0d reads=%0d dp_starts=%0d done_edge=%0d error=%0b",
                 wr_q.size(), rd_q.size(), dps_cnt, done_edge, error);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b0; start = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, enable_read, read_address, load_weight, load_feature,
             dp_start, wr_en, wr_row, wr_col, wr_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got busy=%0b done=%0b err=%0b en=%0b addr=%h wr=%0b exp all 0",
                     busy, done, error, enable_read, read_address, wr_en);
        end
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%0b done=%0b err=%0b exp 0 0 0", busy, done, error);
        end
    endtask

    task automatic test_run_n0;
        prep(0, 1'b0, 0);
        collect_run(200);
        checks++;
        if (done_edge != 57) begin
            errors++; $display("FAIL n0_done_edge got %0d exp 57", done_edge);
        end
        checks++;
        if (first_dps_edge != 2 || first_wr_edge != 3) begin
            errors++; $display("FAIL n0_first_edges got dps=%0d wr=%0d exp 2 3", first_dps_edge, first_wr_edge);
        end
        checks++;
        if (wr_q.size() != 18) begin
            errors++; $display("FAIL n0_wr_count got %0d exp 18", wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 18; i++) begin
            checks++;
            if (wr_q[i] !== exp_wr(i)) begin
                errors++; $display("FAIL n0_write[%0d] got %h exp %h", i, wr_q[i], exp_wr(i));
            end
        end
        checks++;
        if (rd_q.size() != 21) begin
            errors++; $display("FAIL n0_rd_count got %0d exp 21", rd_q.size());
        end
        for (int i = 0; i < rd_q.size() && i < 21; i++) begin
            checks++;
            if (rd_q[i] !== exp_rd(i)) begin
                errors++; $display("FAIL n0_read[%0d] got %h exp %h", i, rd_q[i], exp_rd(i));
            end
        end
        checks++;
        if (error !== 1'b0 || busy !== 1'b0 || busy_gap != 0) begin
            errors++; $display("FAIL n0_status got err=%0b busy=%0b gaps=%0d exp 0 0 0", error, busy, busy_gap);
        end
    endtask

    task automatic test_done_hold;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b1 || enable_read !== 1'b0 || dp_start !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL done_hold[%0d] got done=%0b en=%0b dps=%0b busy=%0b exp 1 0 0 0",
                         k, done, enable_read, dp_start, busy);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_drop got done=%0b busy=%0b exp 0 0", done, busy);
        end
        collect_run(200);
        checks++;
        if (done_edge != 57 || wr_q.size() != 18) begin
            errors++; $display("FAIL rerun_shape got done_edge=%0d writes=%0d exp 57 18", done_edge, wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 18; i++) begin
            checks++;
            if (wr_q[i] !== exp_wr(i)) begin
                errors++; $display("FAIL rerun_write[%0d] got %h exp %h", i, wr_q[i], exp_wr(i));
            end
        end
    endtask

    task automatic test_run_n4;
        prep(4, 1'b1, 0);
        collect_run(300);
        checks++;
        if (done_edge != 129) begin
            errors++; $display("FAIL n4_done_edge got %0d exp 129", done_edge);
        end
        checks++;
        if (dps_cnt != 18 || dps_double != 0) begin
            errors++; $display("FAIL n4_dp_start got count=%0d doubles=%0d exp 18 0", dps_cnt, dps_double);
        end
        checks++;
        if (first_dps_edge != 2 || first_wr_edge != 7) begin
            errors++; $display("FAIL n4_first_edges got dps=%0d wr=%0d exp 2 7", first_dps_edge, first_wr_edge);
        end
        checks++;
        if (wr_q.size() != 18) begin
            errors++; $display("FAIL n4_wr_count got %0d exp 18", wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 18; i++) begin
            checks++;
            if (wr_q[i] !== exp_wr(i)) begin
                errors++; $display("FAIL n4_write[%0d] got %h exp %h", i, wr_q[i], exp_wr(i));
            end
        end
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL n4_error got %0b exp 0", error);
        end
    endtask

    task automatic test_timeout;
        prep(0, 1'b0, 3);
        collect_run(400);
        checks++;
        if (third_dps_edge != 8) begin
            errors++; $display("FAIL wd_third_start got %0d exp 8", third_dps_edge);
        end
        checks++;
        if (done_edge != 264) begin
            errors++; $display("FAIL wd_done_edge got %0d exp 264", done_edge);
        end
        checks++;
        if (error !== 1'b1) begin
            errors++; $display("FAIL wd_error got %0b exp 1", error);
        end
        checks++;
        if (wr_q.size() != 2) begin
            errors++; $display("FAIL wd_wr_count got %0d exp 2", wr_q.size());
        end
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || error !== 1'b1) begin
            errors++; $display("FAIL wd_sticky got done=%0b err=%0b exp 0 1", done, error);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (error !== 1'b0) begin
            errors++; $display("FAIL wd_clear got err=%0b exp 0", error);
        end
        @(posedge clk); #1 reset = 1'b1;
    endtask

    task automatic test_mid_reset;
        int   wc;
        int   dc;
        logic reached;
        prep(4, 1'b0, 0);
        wc = 0; dc = 0; reached = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (wr_en) wc++;
            if (dp_start) dc++;
            if (dc == 10 && !dp_start) begin
                reached = 1'b1;
                break;
            end
        end
        checks++;
        if (!reached) begin
            errors++; $display("FAIL midrst_reach got dp_starts=%0d exp 10 within budget", dc);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL midrst_busy_before got %0b exp 1", busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({busy, done, error, enable_read, read_address, load_weight, load_feature,
             dp_start, wr_en, wr_row, wr_col, wr_data} !== '0) begin
            errors++;
            $display("FAIL midrst_async got busy=%0b done=%0b en=%0b dps=%0b wr=%0b exp all 0",
                     busy, done, enable_read, dp_start, wr_en);
        end
        checks++;
        if (wc != 9) begin
            errors++; $display("FAIL midrst_prior_writes got %0d exp 9", wc);
        end
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (wr_en !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL midrst_hold got wr=%0b busy=%0b exp 0 0", wr_en, busy);
            end
        end
        start = 1'b0;
        reset = 1'b1;
        prep(0, 1'b0, 0);
        collect_run(200);
        checks++;
        if (done_edge != 57 || wr_q.size() != 18) begin
            errors++; $display("FAIL midrst_rerun got done_edge=%0d writes=%0d exp 57 18", done_edge, wr_q.size());
        end
        for (int i = 0; i < wr_q.size() && i < 18; i++) begin
            checks++;
            if (wr_q[i] !== exp_wr(i)) begin
                errors++; $display("FAIL midrst_write[%0d] got %h exp %h", i, wr_q[i], exp_wr(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_n0();
        test_done_hold();
        test_run_n4();
        test_timeout();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gcn_transform_sched.md
# gcn_transform_sched

Sequencer for the GCN transformation (combination) phase: computes FM×WM one output element at a time by fetching a weight column and a feature row from the shared read port, launching the dot-product unit, and writing each 16-bit result into FM_WM memory at [row][col]. Sits between the top-level start/done handshake and the aggregation stage. Owns the shared `read_address`/`enable_read` port while busy. Includes a watchdog on the dot-product handshake.

## Interface
- FEATURE_ROWS, 6, rows of feature matrix (graph nodes)
- WEIGHT_COLS, 3, columns of weight matrix (classes)
- ADDRESS_WIDTH, 13, read-port address width
- FEATURE_BASE, 13'h200, read address of feature row 0; weight column c is at address c
- DOT_PROD_WIDTH, 16, dot-product result width
- DP_TIMEOUT, 255, max cycles waited for `dp_done` after launch
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  level request; sampled in IDLE
- enable_read  out  1  read-port strobe; data valid same cycle (combinational memory)
- read_address  out  ADDRESS_WIDTH  read-port address
- load_weight  out  1  capture `data_in` into weight register this cycle
- load_feature  out  1  capture `data_in` into feature register this cycle
- dp_start  out  1  one-cycle launch pulse to dot-product unit
- dp_done  in  1  dot-product result valid (one-cycle pulse)
- dp_result  in  DOT_PROD_WIDTH  dot-product result, valid with `dp_done`
- wr_en  out  1  FM_WM memory write strobe
- wr_row  out  $clog2(FEATURE_ROWS)  write row index
- wr_col  out  $clog2(WEIGHT_COLS)  write column index
- wr_data  out  DOT_PROD_WIDTH  write data
- busy  out  1  high in any state other than IDLE/DONE
- done  out  1  phase complete
- error  out  1  watchdog expired; sticky until reset

## Operation
- States: IDLE, LOAD_W, LOAD_F, START, WAIT, WRITE, DONE. Counters `row`, `col`, `wd` (watchdog). All outputs decoded from state/counters (Moore).
- IDLE: all outputs 0. `start`=1 → LOAD_W with row=col=0.
- LOAD_W (1 cycle): enable_read=1, read_address=col, load_weight=1 → LOAD_F.
- LOAD_F (1 cycle): enable_read=1, read_address=FEATURE_BASE+row, load_feature=1 → START.
- START (1 cycle): dp_start=1, wd cleared. dp_done=1 here → capture dp_result, → WRITE; else → WAIT.
- WAIT: dp_done=1 → capture, → WRITE. wd increments each cycle; wd reaches DP_TIMEOUT without dp_done → error=1, → DONE (no write).
- WRITE (1 cycle): wr_en=1, wr_row=row, wr_col=col, wr_data=captured result. Then: row<FEATURE_ROWS-1 → row+1, LOAD_F. row=FEATURE_ROWS-1 and col<WEIGHT_COLS-1 → row=0, col+1, LOAD_W. Both at max → DONE.
- DONE: done=1 held while `start`=1; `start`=0 → IDLE (done drops). No restart without `start` low for ≥1 cycle.
- Order of writes: column-major (col 0 rows 0..5, col 1 rows 0..5, …).
- dp_done outside START/WAIT ignored. dp_result not truncated; stored exactly as received.
- enable_read=0 and read_address=0 in every state except LOAD_W/LOAD_F.

## Timing
- Reset (reset=0, any time, asynchronous): state=IDLE, row=col=wd=0, captured result=0, error=0; every output 0 immediately. Mid-phase reset abandons work; no partial write completes.
- With dp_done arriving N cycles after the START cycle (N=0: same cycle), per-element cost 3+N cycles; per-column overhead 1 cycle.
- `done` rises on the WEIGHT_COLS×(1+FEATURE_ROWS×(3+N))-th rising edge after the edge that samples `start`=1 in IDLE (defaults, N=0: edge 57).
- First `dp_start` on edge 2 after start sampled; first `wr_en` on edge 3+N.
- Watchdog: error and done rise DP_TIMEOUT+1 edges after the START cycle when dp_done never arrives.
- `start` dropping mid-phase has no effect; only sampled in IDLE and DONE.

## Test plan
- Reset then start=1, dot-product model with N=0 returning row*16+col: 18 writes, column-major, wr_data matching; done at edge 57; read addresses 0,0x200..0x205,1,0x200..,2,…
- Same with N=4: done at edge 3×(1+6×7)=129; dp_start exactly one cycle per element; dp_done pulses injected during LOAD_F/WRITE ignored.
- Hold dp_done low after third dp_start: error=1 and done=1 at DP_TIMEOUT+1 edges after that START; only 2 writes occurred.
- Assert reset=0 mid-WAIT of element (row 3, col 1): all outputs 0 asynchronously; restart completes full 18 writes from (0,0).
- Hold start=1 after done: done stays 1, no new reads; drop start for 1 cycle then raise: second full run, identical write sequence.
